// File: rtl/sigmoid_pwl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sigmoid_pwl_unit
//  Purpose  : Two-stage piecewise-linear sigmoid with per-packet argmax mode.
//  Revision : 1.0
// ============================================================================
module sigmoid_pwl_unit #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [IDX_W-1:0]  in_idx_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [FRAC_W:0]   out_data_o,
    output logic [IDX_W-1:0]  out_idx_o,
    output logic              out_last_o
);

    localparam int          OUT_W     = FRAC_W + 1;
    localparam int unsigned C_ONE     = 1 << FRAC_W;
    localparam int unsigned C_SAT_TH  = 5 << FRAC_W;
    localparam int unsigned C_MID_TH  = (19 << FRAC_W) / 8;
    localparam logic [OUT_W-1:0] C_ONE_O  = OUT_W'(C_ONE);
    localparam logic [OUT_W-1:0] C_OFF2_O = OUT_W'((27 * C_ONE + 16) / 32);
    localparam logic [OUT_W-1:0] C_OFF1_O = OUT_W'((5 * C_ONE + 4) / 8);
    localparam logic [OUT_W-1:0] C_OFF0_O = OUT_W'((C_ONE + 1) / 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACT  = 2'd1,
        ST_ARG  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              s1_valid_q, s1_neg_q, s1_last_q, s1_arg_q, s1_first_q, s1_emit_q;
    logic [DATA_W-1:0] s1_a_q;
    logic [1:0]        s1_seg_q;
    logic [IDX_W-1:0]  s1_idx_q;

    logic              out_valid_q, out_last_q;
    logic [OUT_W-1:0]  out_data_q, best_val_q;
    logic [IDX_W-1:0]  out_idx_q, best_idx_q;

    logic              w_adv, w_accept, w_beat_arg, w_first;
    logic              w_neg, w_min, w_take;
    logic [DATA_W-1:0] w_abs;
    logic [1:0]        w_seg;
    logic [OUT_W-1:0]  w_y, w_res, w_win_val;
    logic [IDX_W-1:0]  w_win_idx;

    assign w_adv      = !out_valid_q || out_ready_i;
    assign in_ready_o = w_adv && !rst;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_first    = (state_q == ST_IDLE);
    // Mode is only honoured on the first beat; mid-packet beats follow the packet type.
    assign w_beat_arg = w_first ? mode_i : (state_q == ST_ARG);

    always_comb begin
        state_d = state_q;
        if (w_accept) begin
            if (in_last_i) begin
                state_d = ST_IDLE;
            end else begin
                state_d = w_beat_arg ? ST_ARG : ST_ACT;
            end
        end
    end

    // Stage 1: magnitude (most-negative input saturates), sign and segment.
    assign w_neg = in_data_i[DATA_W-1];
    assign w_min = w_neg && (in_data_i[DATA_W-2:0] == '0);
    assign w_abs = !w_neg ? in_data_i : (w_min ? {1'b0, {(DATA_W-1){1'b1}}} : -in_data_i);

    always_comb begin
        w_seg = 2'd0;
        if (32'(w_abs) >= C_SAT_TH) begin
            w_seg = 2'd3;
        end else if (32'(w_abs) >= C_MID_TH) begin
            w_seg = 2'd2;
        end else if (32'(w_abs) >= C_ONE) begin
            w_seg = 2'd1;
        end
    end

    // Stage 2: segment evaluation; each non-saturated segment stays below 1.0.
    always_comb begin
        w_y = C_ONE_O;
        case (s1_seg_q)
            2'd3:    w_y = C_ONE_O;
            2'd2:    w_y = OUT_W'(s1_a_q >> 5) + C_OFF2_O;
            2'd1:    w_y = OUT_W'(s1_a_q >> 3) + C_OFF1_O;
            default: w_y = OUT_W'(s1_a_q >> 2) + C_OFF0_O;
        endcase
        if (w_y > C_ONE_O) begin
            w_y = C_ONE_O;
        end
        w_res = s1_neg_q ? (C_ONE_O - w_y) : w_y;
    end

    // Strictly-greater comparison keeps the earliest index on ties.
    assign w_take    = s1_first_q || (w_res > best_val_q);
    assign w_win_val = w_take ? w_res    : best_val_q;
    assign w_win_idx = w_take ? s1_idx_q : best_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s1_valid_q  <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_arg_q    <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_emit_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_seg_q    <= 2'd0;
            s1_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            if (w_adv) begin
                s1_valid_q <= in_valid_i;
                if (in_valid_i) begin
                    s1_a_q     <= w_abs;
                    s1_neg_q   <= w_neg;
                    s1_seg_q   <= w_seg;
                    s1_idx_q   <= in_idx_i;
                    s1_last_q  <= in_last_i;
                    s1_arg_q   <= w_beat_arg;
                    s1_first_q <= w_first;
                    s1_emit_q  <= !w_beat_arg || in_last_i;
                end
                out_valid_q <= s1_valid_q && s1_emit_q;
                if (s1_valid_q && s1_emit_q) begin
                    out_data_q <= s1_arg_q ? w_win_val : w_res;
                    out_idx_q  <= s1_arg_q ? w_win_idx : s1_idx_q;
                    out_last_q <= s1_arg_q || s1_last_q;
                end
                if (s1_valid_q && s1_arg_q) begin
                    best_val_q <= w_win_val;
                    best_idx_q <= w_win_idx;
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
    assign out_last_o  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_pwl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sigmoid_pwl_unit
//  Purpose  : Directed table-driven bench for sigmoid_pwl_unit.
//  Revision : 1.0
// ============================================================================
module tb_sigmoid_pwl_unit;

    localparam int NV = 27;

    typedef struct {
        logic               mode;
        logic signed [15:0] x;
        logic [7:0]         idx;
        logic               last;
        logic               chk;
        logic [12:0]        ed;
        logic [7:0]         ei;
        logic               el;
    } vec_t;

    typedef struct {
        logic [12:0] d;
        logic [7:0]  i;
        logic        l;
        int          c;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [7:0]  in_idx = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [12:0] out_data;
    logic [7:0]  out_idx;
    logic        out_last;

    vec_t vt [0:NV-1];
    out_t expq[$];
    out_t capq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   tog = 1'b0;

    logic        pv = 1'b0, pr = 1'b1, pl = 1'b0;
    logic [12:0] pd = '0;
    logic [7:0]  pi = '0;

    sigmoid_pwl_unit #(.DATA_W(16), .FRAC_W(12), .IDX_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (mode),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_idx_i    (in_idx),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic vec_t mk(bit m, int x, int idx, bit l, bit c, int ed, int ei, bit el);
        vec_t v;
        v.mode = m;   v.x  = 16'(x);  v.idx = 8'(idx); v.last = l;
        v.chk  = c;   v.ed = 13'(ed); v.ei  = 8'(ei);  v.el   = el;
        return v;
    endfunction

    // Output capture plus hold-while-stalled checking.
    always @(negedge clk) begin
        if (!rst && pv && !pr) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data",  int'(out_data),  int'(pd));
            chk("stall_idx",   int'(out_idx),   int'(pi));
            chk("stall_last",  int'(out_last),  int'(pl));
        end
        pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx; pl = out_last;
        if (out_valid && out_ready) begin
            out_t o;
            o.d = out_data; o.i = out_idx; o.l = out_last; o.c = cyc;
            capq.push_back(o);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) out_ready = ~out_ready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(int n);
        int w = 0;
        int acc;
        mode = vt[n].mode; in_data = vt[n].x; in_idx = vt[n].idx; in_last = vt[n].last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        acc = cyc;
        if (vt[n].chk) begin
            out_t e;
            e.d = vt[n].ed; e.i = vt[n].ei; e.l = vt[n].el; e.c = tog ? -1 : acc + 2;
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w = 0;
        while (capq.size() < expq.size() && w < 100) begin
            @(posedge clk);
            w++;
        end
        repeat (5) @(posedge clk);
        chk("out_count", capq.size(), expq.size());
        for (int k = 0; k < expq.size() && k < capq.size(); k++) begin
            chk("out_data", int'(capq[k].d), int'(expq[k].d));
            chk("out_idx",  int'(capq[k].i), int'(expq[k].i));
            chk("out_last", int'(capq[k].l), int'(expq[k].l));
            if (expq[k].c >= 0) chk("out_latency", capq[k].c, expq[k].c);
        end
        expq.delete();
        capq.delete();
    endtask

    task automatic run_group(int lo, int hi, bit t);
        tog = t;
        for (int n = lo; n <= hi; n++) send(n);
        in_valid = 1'b0;
        drain();
        tog = 1'b0;
        out_ready = 1'b1;
        #1;
    endtask

    initial begin
        // Group 1: mode 0 basic points, full throughput
        vt[0]  = mk(0,      0, 0, 0, 1, 2048, 0, 0);
        vt[1]  = mk(0,   4096, 1, 0, 1, 3072, 1, 0);
        vt[2]  = mk(0,  -4096, 2, 0, 1, 1024, 2, 0);
        vt[3]  = mk(0,   8192, 3, 0, 1, 3584, 3, 0);
        vt[4]  = mk(0,  20480, 4, 0, 1, 4096, 4, 0);
        vt[5]  = mk(0, -24576, 5, 1, 1,    0, 5, 1);
        // Group 2: mode 0 segment edges under backpressure toggling
        vt[6]  = mk(0,   2048, 10, 0, 1, 2560, 10, 0);
        vt[7]  = mk(0,  -2048, 11, 0, 1, 1536, 11, 0);
        vt[8]  = mk(0,  12288, 12, 0, 1, 3840, 12, 0);
        vt[9]  = mk(0, -12288, 13, 0, 1,  256, 13, 0);
        vt[10] = mk(0,   9728, 14, 0, 1, 3760, 14, 0);
        vt[11] = mk(0,   9727, 15, 0, 1, 3775, 15, 0);
        vt[12] = mk(0,  20479, 16, 0, 1, 4095, 16, 0);
        vt[13] = mk(0, -32768, 17, 0, 1,    0, 17, 0);
        vt[14] = mk(0,   4095, 18, 0, 1, 3071, 18, 0);
        vt[15] = mk(0,     -1, 19, 1, 1, 2048, 19, 1);
        // Group 3: argmax with tie; mode flips mid-packet must be ignored
        vt[16] = mk(1,  -4096, 0, 0, 0,    0, 0, 0);
        vt[17] = mk(0,   8192, 1, 0, 0,    0, 0, 0);
        vt[18] = mk(0,   8192, 2, 0, 0,    0, 0, 0);
        vt[19] = mk(0,      0, 3, 1, 1, 3584, 1, 1);
        // Group 4: both saturate, earliest wins
        vt[20] = mk(1,  20480, 7, 0, 0,    0, 0, 0);
        vt[21] = mk(1,  24576, 8, 1, 1, 4096, 7, 1);
        // Group 5: single-beat argmax packet then single-beat activation packet
        vt[22] = mk(1,  -4096, 9, 1, 1, 1024, 9, 1);
        vt[23] = mk(0,   4096, 3, 1, 1, 3072, 3, 1);
        // Reset test: partial argmax packet, then fresh activation
        vt[24] = mk(1,   4096, 0, 0, 0,    0, 0, 0);
        vt[25] = mk(1,   8192, 1, 0, 0,    0, 0, 0);
        vt[26] = mk(0,      0, 5, 1, 1, 2048, 5, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),  0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data),  0);
        chk("rst_out_idx",   int'(out_idx),   0);
        chk("rst_out_last",  int'(out_last),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_group(0, 5, 1'b0);
        run_group(6, 15, 1'b1);
        run_group(16, 19, 1'b0);
        run_group(20, 21, 1'b0);
        run_group(22, 23, 1'b0);

        send(24);
        send(25);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_no_stale", capq.size(), 0);
        send(26);
        in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
